// File: rtl/ws2811_pkg.sv
// rtl/ws2811_pkg.sv - shared timing constants, state and colour-order encodings for the WS2811 serialiser
package ws2811_pkg;

   localparam int T0H_50MHZ   = 13;
   localparam int T1H_50MHZ   = 30;
   localparam int TBIT_50MHZ  = 63;
   localparam int RESET_50MHZ = 2600;

   localparam int COLOR_RGB = 0;
   localparam int COLOR_GRB = 1;

   typedef enum logic {
      GAP  = 1'b0,
      SEND = 1'b1
   } state_t;

   // One counter serves both the latch gap and the bit period, so size it for the larger.
   function automatic int cnt_width(input int reset_cycles, input int tbit_cycles);
      int w;
      w = 12;
      if ($clog2(reset_cycles) > w) w = $clog2(reset_cycles);
      if ($clog2(tbit_cycles) > w) w = $clog2(tbit_cycles);
      return w;
   endfunction

   function automatic logic [23:0] pack_pixel(input int order, input logic [7:0] r,
                                              input logic [7:0] g, input logic [7:0] b);
      return (order == COLOR_GRB) ? {g, r, b} : {r, g, b};
   endfunction

endpackage

// File: rtl/ws2811_serialiser_if.sv
// rtl/ws2811_serialiser_if.sv - colour fetch and strip output signals of the WS2811 serialiser
interface ws2811_serialiser_if;

   logic       enable;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [7:0] ledindex;
   logic       dout;
   logic       busy;
   logic       frame_done;

   modport master (
      input  enable, red, green, blue,
      output ledindex, dout, busy, frame_done
   );

   modport slave (
      output enable, red, green, blue,
      input  ledindex, dout, busy, frame_done
   );

endinterface

// File: rtl/ws2811_bit_encoder.sv
// rtl/ws2811_bit_encoder.sv - WS2811 bit waveform: registered data line and end-of-bit strobe
module ws2811_bit_encoder #(
   parameter int T0H_CYCLES  = 13,
   parameter int T1H_CYCLES  = 30,
   parameter int TBIT_CYCLES = 63,
   parameter int CW          = 12
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CW-1:0] cnt,
   input  logic          active_d,
   input  logic [CW-1:0] cnt_d,
   input  logic          bit_d,
   output logic          dout,
   output logic          bit_end
);

   assign bit_end = (cnt == CW'(TBIT_CYCLES - 1));

   // Fed with next-cycle values so the registered line lines up with the counter it describes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dout <= 1'b0;
      end else begin
         dout <= active_d && (cnt_d < (bit_d ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
      end
   end

endmodule

// File: rtl/ws2811_serialiser.sv
// rtl/ws2811_serialiser.sv - frame sequencer: prefetches pixel colours and streams 24-bit WS2811 words
module ws2811_serialiser
   import ws2811_pkg::*;
#(
   parameter int NUM_LEDS     = 50,
   parameter int T0H_CYCLES   = T0H_50MHZ,
   parameter int T1H_CYCLES   = T1H_50MHZ,
   parameter int TBIT_CYCLES  = TBIT_50MHZ,
   parameter int RESET_CYCLES = RESET_50MHZ,
   parameter int COLOR_ORDER  = COLOR_RGB
) (
   input  logic                 clk,
   input  logic                 reset,
   ws2811_serialiser_if.master  bus
);

   localparam int CW = cnt_width(RESET_CYCLES, TBIT_CYCLES);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [23:0]   shift_q, shift_d;
   logic [4:0]    bit_q, bit_d;
   logic [7:0]    pix_q, pix_d;
   logic [7:0]    idx_q, idx_d;
   logic          fd_q, fd_d;
   logic          bit_end;
   logic [23:0]   pixel_in;
   logic [8:0]    idx_inc;
   logic [7:0]    idx_wrap;

   assign pixel_in = pack_pixel(COLOR_ORDER, bus.red, bus.green, bus.blue);
   assign idx_inc  = {1'b0, idx_q} + 9'd1;
   assign idx_wrap = (idx_inc == 9'(NUM_LEDS)) ? 8'd0 : idx_inc[7:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= GAP;
         cnt_q   <= '0;
         shift_q <= '0;
         bit_q   <= '0;
         pix_q   <= '0;
         idx_q   <= '0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         pix_q   <= pix_d;
         idx_q   <= idx_d;
         fd_q    <= fd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      bit_d   = bit_q;
      pix_d   = pix_q;
      idx_d   = idx_q;
      fd_d    = 1'b0;
      case (state_q)
         GAP: begin
            idx_d = 8'd0;
            if (cnt_q != CW'(RESET_CYCLES - 1)) begin
               cnt_d = cnt_q + CW'(1);
            end else if (bus.enable) begin
               // ledindex moves on as soon as pixel 0 is captured: the prefetch window is a whole pixel.
               shift_d = pixel_in;
               idx_d   = (NUM_LEDS == 1) ? 8'd0 : 8'd1;
               pix_d   = 8'd0;
               bit_d   = 5'd0;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (!bit_end) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d   = '0;
               shift_d = {shift_q[22:0], 1'b0};
               bit_d   = bit_q + 5'd1;
               if (bit_q == 5'd23) begin
                  bit_d = 5'd0;
                  if (pix_q == 8'(NUM_LEDS - 1)) begin
                     state_d = GAP;
                     idx_d   = 8'd0;
                     fd_d    = 1'b1;
                  end else begin
                     shift_d = pixel_in;
                     pix_d   = pix_q + 8'd1;
                     idx_d   = idx_wrap;
                  end
               end
            end
         end
         default: state_d = GAP;
      endcase
   end

   always_comb begin
      bus.busy       = (state_q == SEND);
      bus.ledindex   = idx_q;
      bus.frame_done = fd_q;
   end

   ws2811_bit_encoder #(
      .T0H_CYCLES (T0H_CYCLES),
      .T1H_CYCLES (T1H_CYCLES),
      .TBIT_CYCLES(TBIT_CYCLES),
      .CW         (CW)
   ) u_bit_encoder (
      .clk     (clk),
      .reset   (reset),
      .cnt     (cnt_q),
      .active_d(state_d == SEND),
      .cnt_d   (cnt_d),
      .bit_d   (shift_d[23]),
      .dout    (bus.dout),
      .bit_end (bit_end)
   );

endmodule

// File: tb/tb_ws2811_serialiser.sv
// tb/tb_ws2811_serialiser.sv - scoreboard bench: RGB and GRB serialisers decoded back to pixel words
module tb_ws2811_serialiser;
   import ws2811_pkg::*;

   localparam int N   = 3;
   localparam int T0H = 2;
   localparam int T1H = 5;
   localparam int TB  = 8;
   localparam int RST = 20;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b1;
   logic cmode = 1'b0;
   int   total = 0;
   int   bad = 0;

   logic [23:0] exp_q0[$];
   logic [23:0] exp_q1[$];

   always #5 clk = ~clk;

   ws2811_serialiser_if bus0();
   ws2811_serialiser_if bus1();

   assign bus0.enable = enable;
   assign bus0.red    = cmode ? bus0.ledindex : 8'hFF;
   assign bus0.green  = cmode ? ~bus0.ledindex : 8'h00;
   assign bus0.blue   = cmode ? 8'h5A : 8'h00;
   assign bus1.enable = enable;
   assign bus1.red    = cmode ? bus1.ledindex : 8'hFF;
   assign bus1.green  = cmode ? ~bus1.ledindex : 8'h00;
   assign bus1.blue   = cmode ? 8'h5A : 8'h00;

   ws2811_serialiser #(.NUM_LEDS(N), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .TBIT_CYCLES(TB),
                       .RESET_CYCLES(RST), .COLOR_ORDER(COLOR_RGB))
      dut0 (.clk(clk), .reset(reset), .bus(bus0));

   ws2811_serialiser #(.NUM_LEDS(N), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H), .TBIT_CYCLES(TB),
                       .RESET_CYCLES(RST), .COLOR_ORDER(COLOR_GRB))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));

   // Decoders: high time per bit gives the bit value, 24 bits form a pixel checked against the queue.
   int          hi0 = 0, nb0 = 0, hi1 = 0, nb1 = 0;
   logic [23:0] px0 = '0, px1 = '0, want0, want1;

   always @(negedge clk) begin
      if (reset) begin
         hi0 = 0; nb0 = 0;
      end else if (bus0.dout) begin
         hi0++;
      end else if (hi0 != 0) begin
         total++;
         if (hi0 != T1H && hi0 != T0H) begin
            bad++;
            $display("FAIL bit_high0 got=%0d want=%0d_or_%0d", hi0, T0H, T1H);
         end
         px0 = {px0[22:0], (hi0 == T1H)};
         hi0 = 0;
         nb0++;
         if (nb0 == 24) begin
            nb0 = 0;
            total++;
            if (exp_q0.size() == 0) begin
               bad++;
               $display("FAIL pixel0_unexpected got=%h want=none", px0);
            end else begin
               want0 = exp_q0.pop_front();
               if (px0 !== want0) begin
                  bad++;
                  $display("FAIL pixel0 got=%h want=%h", px0, want0);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         hi1 = 0; nb1 = 0;
      end else if (bus1.dout) begin
         hi1++;
      end else if (hi1 != 0) begin
         total++;
         if (hi1 != T1H && hi1 != T0H) begin
            bad++;
            $display("FAIL bit_high1 got=%0d want=%0d_or_%0d", hi1, T0H, T1H);
         end
         px1 = {px1[22:0], (hi1 == T1H)};
         hi1 = 0;
         nb1++;
         if (nb1 == 24) begin
            nb1 = 0;
            total++;
            if (exp_q1.size() == 0) begin
               bad++;
               $display("FAIL pixel1_unexpected got=%h want=none", px1);
            end else begin
               want1 = exp_q1.pop_front();
               if (px1 !== want1) begin
                  bad++;
                  $display("FAIL pixel1 got=%h want=%h", px1, want1);
               end
            end
         end
      end
   end

   task automatic push_frame(input logic m);
      for (int i = 0; i < N; i++) begin
         logic [7:0] r, g, b;
         r = m ? 8'(i) : 8'hFF;
         g = m ? ~8'(i) : 8'h00;
         b = m ? 8'h5A : 8'h00;
         exp_q0.push_back({r, g, b});
         exp_q1.push_back({g, r, b});
      end
   endtask

   task automatic wait_frame_done(input int limit, output int cycles, output bit seen);
      seen = 0;
      cycles = 0;
      while (!seen && cycles < limit) begin
         @(negedge clk);
         cycles++;
         if (bus0.frame_done) seen = 1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; enable = 1'b1; cmode = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus0.dout !== 1'b0) begin bad++; $display("FAIL reset_dout got=%b want=0", bus0.dout); end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus0.busy); end
      total++; if (bus0.ledindex !== 8'd0) begin bad++; $display("FAIL reset_ledindex got=%0d want=0", bus0.ledindex); end
      total++; if (bus0.frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", bus0.frame_done); end
   endtask

   task automatic test_colour_order;
      int n, cyc;
      bit seen;
      push_frame(1'b0);
      reset = 1'b0;
      n = 0;
      while (bus0.dout !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      total++; if (n != RST) begin bad++; $display("FAIL first_high got=%0d want=%0d", n, RST); end
      wait_frame_done(2000, cyc, seen);
      enable = 1'b0;
      total++; if (!seen) begin bad++; $display("FAIL frame_done_order got=timeout want=pulse"); end
      total++; if (exp_q0.size() != 0) begin bad++; $display("FAIL rgb_left got=%0d want=0", exp_q0.size()); end
      total++; if (exp_q1.size() != 0) begin bad++; $display("FAIL grb_left got=%0d want=0", exp_q1.size()); end
   endtask

   task automatic test_late_enable_prefetch;
      int idle_bad, cyc;
      logic [7:0] seq[$];
      logic [7:0] want_seq[4];
      want_seq = '{8'd0, 8'd1, 8'd2, 8'd0};
      cmode = 1'b1;
      push_frame(1'b1);
      idle_bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (bus0.dout !== 1'b0 || bus0.busy !== 1'b0) idle_bad++;
      end
      total++; if (idle_bad != 0) begin bad++; $display("FAIL gap_idle got=%0d want=0", idle_bad); end
      total++; if (bus0.ledindex !== 8'd0) begin bad++; $display("FAIL gap_ledindex got=%0d want=0", bus0.ledindex); end
      seq.push_back(bus0.ledindex);
      enable = 1'b1;
      @(negedge clk);
      total++; if (bus0.busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", bus0.busy); end
      total++; if (bus0.dout !== 1'b1) begin bad++; $display("FAIL start_dout got=%b want=1", bus0.dout); end
      cyc = 0;
      while (bus0.frame_done !== 1'b1 && cyc < 2000) begin
         if (bus0.ledindex !== seq[$]) seq.push_back(bus0.ledindex);
         @(negedge clk);
         cyc++;
      end
      total++; if (cyc != N * 24 * TB) begin bad++; $display("FAIL frame_done_time got=%0d want=%0d", cyc, N * 24 * TB); end
      total++;
      if (seq.size() != 4) begin
         bad++; $display("FAIL index_seq_len got=%0d want=4", seq.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (seq[i] !== want_seq[i]) begin
               bad++; $display("FAIL index_seq[%0d] got=%0d want=%0d", i, seq[i], want_seq[i]);
            end
         end
      end
      @(negedge clk);
      total++; if (bus0.frame_done !== 1'b0) begin bad++; $display("FAIL frame_done_width got=%b want=0", bus0.frame_done); end
      total++; if (exp_q0.size() != 0) begin bad++; $display("FAIL prefetch_left got=%0d want=0", exp_q0.size()); end
   endtask

   task automatic test_enable_drop;
      int n, cyc, idle_bad;
      bit seen;
      push_frame(1'b1);
      n = 0;
      while (bus0.ledindex !== 8'd2 && n < 1000) begin @(negedge clk); n++; end
      total++; if (n >= 1000) begin bad++; $display("FAIL drop_reach_pixel1 got=timeout want=ledindex2"); end
      enable = 1'b0;
      wait_frame_done(2000, cyc, seen);
      total++; if (!seen) begin bad++; $display("FAIL drop_frame_done got=timeout want=pulse"); end
      total++; if (exp_q0.size() != 0) begin bad++; $display("FAIL drop_left got=%0d want=0", exp_q0.size()); end
      idle_bad = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus0.dout !== 1'b0 || bus0.busy !== 1'b0) idle_bad++;
      end
      total++; if (idle_bad != 0) begin bad++; $display("FAIL drop_stays_gap got=%0d want=0", idle_bad); end
   endtask

   task automatic test_reset_mid_frame;
      int n, cyc;
      bit seen;
      enable = 1'b1;
      push_frame(1'b1);
      n = 0;
      while (bus0.ledindex !== 8'd2 && n < 1000) begin @(negedge clk); n++; end
      total++; if (n >= 1000) begin bad++; $display("FAIL rst_reach_pixel1 got=timeout want=ledindex2"); end
      repeat (10 * TB + 3) @(negedge clk);
      reset = 1'b1;
      #1;
      total++; if (bus0.dout !== 1'b0) begin bad++; $display("FAIL rst_mid_dout got=%b want=0", bus0.dout); end
      total++; if (bus0.busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", bus0.busy); end
      total++; if (bus0.ledindex !== 8'd0) begin bad++; $display("FAIL rst_mid_ledindex got=%0d want=0", bus0.ledindex); end
      total++; if (bus1.dout !== 1'b0) begin bad++; $display("FAIL rst_mid_dout1 got=%b want=0", bus1.dout); end
      total++; if (exp_q0.size() != 2) begin bad++; $display("FAIL rst_pixels_pending got=%0d want=2", exp_q0.size()); end
      exp_q0.delete();
      exp_q1.delete();
      push_frame(1'b1);
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      while (bus0.dout !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      total++; if (n != RST) begin bad++; $display("FAIL rst_gap got=%0d want=%0d", n, RST); end
      wait_frame_done(2000, cyc, seen);
      enable = 1'b0;
      total++; if (!seen) begin bad++; $display("FAIL rst_frame_done got=timeout want=pulse"); end
      total++; if (exp_q0.size() != 0) begin bad++; $display("FAIL rst_left got=%0d want=0", exp_q0.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_colour_order();
      test_late_enable_prefetch();
      test_enable_drop();
      test_reset_mid_frame();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ws2811_serialiser.md
Name: ws2811_serialiser

Overview:
- Downstream stage of the LED colour pipeline. It drives `ledindex` into the colour controller, samples the returned `red`/`green`/`blue`, and serialises each pixel as 24 WS2811-timed bits on one data line.
- Each frame is followed by a latch (reset) gap.
- It sits between the colour controller and the strip output pin.
- It prefetches: the next pixel's index is presented a full pixel time (24 bit periods) before its colour is sampled, which covers the controller's 8-cycle phase pipeline.

Parameters:
- NUM_LEDS, 50, pixels per frame; legal range 1..256.
- T0H_CYCLES, 13, high time of a '0' bit in clk cycles (0.26 us at 50 MHz).
- T1H_CYCLES, 30, high time of a '1' bit in clk cycles.
- TBIT_CYCLES, 63, full bit period in clk cycles. Must be greater than T1H_CYCLES.
- RESET_CYCLES, 2600, low latch gap between frames (52 us at 50 MHz). Must be at least 16.
- COLOR_ORDER, 0, wire order: 0 = R,G,B; 1 = G,R,B. Each byte is sent MSB first.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- enable, input, 1, allows a new frame to start; sampled only at the end of the latch gap.
- red, input, 8, colour of pixel `ledindex`, from the colour controller.
- green, input, 8, as above.
- blue, input, 8, as above.
- ledindex, output, 8, index of the next pixel whose colour will be sampled.
- dout, output, 1, registered serial data to the strip.
- busy, output, 1, high while bits are being sent.
- frame_done, output, 1, one-cycle pulse when the last bit of a frame completes.

Behaviour:
- On reset (asynchronous):
  - `dout`=0, `ledindex`=0, `busy`=0, `frame_done`=0.
  - State = GAP; cycle counter, bit counter and pixel counter = 0; shift register = 0.
  - Reset asserted mid-frame truncates the frame. The line goes low immediately, and a full gap runs after release.
- State GAP:
  - `dout`=0, `busy`=0, `ledindex`=0.
  - The cycle counter counts 0..RESET_CYCLES-1, then holds at the terminal value.
  - At the terminal value with `enable`=1:
    - Load the 24-bit shift register from {r,g,b} or {g,r,b} according to COLOR_ORDER.
    - `ledindex` <= 1, or 0 if NUM_LEDS=1.
    - Pixel counter = 0, bit counter = 0, cycle counter = 0.
    - Go to SEND.
  - At the terminal value with `enable`=0: stay in GAP. Check `enable` again every cycle.
- State SEND:
  - `busy`=1.
  - `dout` = 1 when cycle counter < (shift MSB ? T1H_CYCLES : T0H_CYCLES), else 0. `dout` is registered, so the first high cycle follows the GAP→SEND transition cycle.
  - The cycle counter counts 0..TBIT_CYCLES-1 and wraps to 0.
  - On wrap: shift left one bit and increment the bit counter.
  - On wrap when bit counter = 23:
    - If pixel counter = NUM_LEDS-1: go to GAP; cycle counter = 0; `ledindex` = 0; `frame_done` = 1 for exactly one cycle.
    - Otherwise: load the shift register from the inputs; increment the pixel counter; `ledindex` <= `ledindex`+1, or 0 when that would reach NUM_LEDS; bit counter = 0.
- Colour inputs are sampled only on load cycles. Changes at any other time have no effect.
- `enable` falling mid-frame has no effect until the current frame ends.
- Frame length in clk cycles = NUM_LEDS*24*TBIT_CYCLES + RESET_CYCLES.
- All counters are sized from the parameters: 12-bit gap counter minimum, 5-bit bit counter, 8-bit pixel counter.

Decomposition:
- Shared package `ws2811_pkg` holds:
  - timing constants for 50 MHz (T0H, T1H, TBIT, RESET);
  - the state enum {GAP, SEND};
  - COLOR_ORDER encodings RGB=0, GRB=1.
- One natural sub-module: `ws2811_bit_encoder`. It takes the current bit and cycle count and produces `dout` plus a bit-end strobe.
- Frame sequencing stays in the top module.

Test Plan:
All scenarios use NUM_LEDS=3, T0H=2, T1H=5, TBIT=8, RESET=20.
1. Release reset with `enable`=1 and constant rgb=FF,00,00, COLOR_ORDER=0 -> `dout` low for 20 cycles, then eight bits each high for 5 of 8 cycles, then sixteen bits each high for 2 of 8 cycles; repeated for 3 pixels.
2. Same as scenario 1 with COLOR_ORDER=1 -> first 8 bits short-high (green=00), next 8 long-high, last 8 short-high.
3. Model the controller as rgb = {ledindex, ~ledindex, 8'h5A} -> sampled pixels carry index 0, 1, 2 in order. `ledindex` sequence is 0,1,2,0. `frame_done` pulses once, 576 cycles after the first SEND cycle.
4. Hold `enable`=0 through the gap, raise it at cycle 100 -> `dout` stays 0 until then; SEND starts the cycle after `enable` is seen high; `busy` rises together with it.
5. Drop `enable` during pixel 1 -> the frame completes fully, `frame_done` pulses, and the serialiser remains in GAP with `dout`=0.
6. Assert `reset` in the middle of bit 10 of pixel 1 -> `dout`, `busy` and `ledindex` are 0 immediately. After release, a full 20-cycle gap precedes a new frame starting at pixel 0.
